// File: rtl/lab_macrocell_array.sv
// MAX7000-style logic array block: true/complement LAB signals, shareable
// expanders, product-term sums and per-macrocell registers, streamed config.
module lab_macrocell_array #(
  parameter int PIA_INPUTS = 36,
  parameter int MACROCELLS = 16,
  parameter int PTERMS     = 5,
  parameter int CFG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PIA_INPUTS-1:0] selected_pia_signals,
  input  logic                  lab_ce,
  input  logic                  cfg_start,
  input  logic                  cfg_valid,
  input  logic [CFG_WIDTH-1:0]  cfg_data,
  output logic                  cfg_ready,
  output logic                  configured,
  output logic [MACROCELLS-1:0] mc_out,
  output logic [MACROCELLS-1:0] expander_out
);
  localparam int P = PIA_INPUTS;
  localparam int M = MACROCELLS;
  localparam int T = PTERMS;
  localparam int W = CFG_WIDTH;
  localparam int L = 2 * P + M;
  localparam int MCW = T * L + 2 * P + 4;
  localparam int CFG_BITS = M * MCW;
  localparam int BEATS = (CFG_BITS + W - 1) / W;
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    UNCONFIG,
    LOADING,
    RUN
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CFG_BITS-1:0] sr_q, sr_d;
  logic [CFG_BITS-1:0] sr_sh;
  logic [M-1:0]        q_q, q_d;
  logic                beat;
  logic                run;

  logic [2*P-1:0] labp;
  logic [2*P-1:0] em;
  logic [L-1:0]   lab;
  logic [L-1:0]   pm;
  logic [M-1:0]   expn;
  logic [M-1:0]   sum;
  logic [M-1:0]   regd;
  logic [1:0]     md;

  // New beat enters at the LSBs; bits shifted past the top are lost.
  if (CFG_BITS > W) begin : g_sh_wide
    assign sr_sh = {sr_q[CFG_BITS-W-1:0], cfg_data};
  end else begin : g_sh_narrow
    assign sr_sh = cfg_data[CFG_BITS-1:0];
  end

  assign beat = (state_q == LOADING) && cfg_valid && !cfg_start;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    if (cfg_start) begin
      state_d = LOADING;
      cnt_d   = '0;
    end else if (beat) begin
      sr_d = sr_sh;
      if (cnt_q == CW'(BEATS - 1)) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    labp = '0;
    for (int i = 0; i < P; i++) begin
      labp[2*P-1-2*i] = selected_pia_signals[i];
      labp[2*P-2-2*i] = ~selected_pia_signals[i];
    end
  end

  // Expanders see only PIA-derived bits, so they cannot loop on themselves.
  always_comb begin
    em   = '0;
    expn = '0;
    for (int m = 0; m < M; m++) begin
      em      = sr_q[m*MCW+4 +: 2*P];
      expn[m] = (em == '0) | ~(&(labp | ~em));
    end
  end

  assign lab = {labp, expn};

  always_comb begin
    pm   = '0;
    md   = '0;
    sum  = '0;
    regd = '0;
    for (int m = 0; m < M; m++) begin
      for (int t = 0; t < T; t++) begin
        pm     = sr_q[m*MCW+4+2*P+t*L +: L];
        sum[m] = sum[m] | ((|pm) & (&(lab | ~pm)));
      end
      sum[m]  = sum[m] ^ sr_q[m*MCW+3];
      md      = sr_q[m*MCW+1 +: 2];
      regd[m] = (md == 2'b01) || (md == 2'b10);
    end
  end

  always_comb begin
    q_d = q_q;
    for (int m = 0; m < M; m++) begin
      if (state_q == LOADING && state_d == RUN) begin
        q_d[m] = sr_d[m*MCW];
      end else if (state_d != RUN) begin
        q_d[m] = 1'b0;
      end else if (lab_ce) begin
        unique case (sr_q[m*MCW+1 +: 2])
          2'b01:   q_d[m] = sum[m];
          2'b10:   q_d[m] = q_q[m] ^ sum[m];
          default: q_d[m] = q_q[m];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNCONFIG;
      cnt_q   <= '0;
      sr_q    <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      q_q     <= q_d;
    end
  end

  assign run          = (state_q == RUN);
  assign cfg_ready    = (state_q == LOADING);
  assign configured   = run;
  assign mc_out       = run ? ((regd & q_q) | (~regd & sum)) : '0;
  assign expander_out = run ? expn : '0;

endmodule

// File: tb/tb_lab_macrocell_array.sv
// Directed bench for lab_macrocell_array at P=2, M=2, T=2, W=8.
// Config words are assembled from the field layout by hand.
module tb_lab_macrocell_array;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] pia;
  logic       lab_ce;
  logic       cfg_start;
  logic       cfg_valid;
  logic [7:0] cfg_data;
  logic       cfg_ready;
  logic       configured;
  logic [1:0] mc_out;
  logic [1:0] expander_out;

  int n_run  = 0;
  int n_fail = 0;
  int acc;

  logic [39:0] ca;
  logic [39:0] cb;
  logic [1:0]  pv;

  always #5 clk = ~clk;

  lab_macrocell_array #(
    .PIA_INPUTS(2),
    .MACROCELLS(2),
    .PTERMS(2),
    .CFG_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .selected_pia_signals(pia),
    .lab_ce(lab_ce),
    .cfg_start(cfg_start),
    .cfg_valid(cfg_valid),
    .cfg_data(cfg_data),
    .cfg_ready(cfg_ready),
    .configured(configured),
    .mc_out(mc_out),
    .expander_out(expander_out)
  );

  function automatic logic [19:0] mcf(
    input logic       pre,
    input logic [1:0] mode,
    input logic       inv,
    input logic [3:0] emask,
    input logic [5:0] t0,
    input logic [5:0] t1
  );
    return {t1, t0, emask, inv, mode, pre};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_run++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [39:0] c);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cfg_valid = 1'b1;
      cfg_data  = c[39-8*k -: 8];
      step();
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    // mc0 bypass: pia0 | ~pia1; mc1 T mode, preset 1, term0 = pia0
    ca = {mcf(1'b1, 2'b10, 1'b0, 4'b0000, 6'b100000, 6'b000000),
          mcf(1'b0, 2'b00, 1'b0, 4'b0000, 6'b100000, 6'b000100)};
    // expander0 = NAND(pia0,pia1); mc1 D, inverted, term0 = lab[0]
    cb = {mcf(1'b0, 2'b01, 1'b1, 4'b0000, 6'b000001, 6'b000000),
          mcf(1'b0, 2'b00, 1'b0, 4'b1010, 6'b000000, 6'b000000)};

    rst_n     = 1'b0;
    pia       = 2'b00;
    lab_ce    = 1'b0;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = 8'h00;
    #3;
    chk("rst_ready", {7'd0, cfg_ready}, 8'd0);
    chk("rst_cfgd", {7'd0, configured}, 8'd0);
    chk("rst_mc", {6'd0, mc_out}, 8'd0);
    chk("rst_exp", {6'd0, expander_out}, 8'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("unconf_ready", {7'd0, cfg_ready}, 8'd0);

    // load with cfg_valid toggling every cycle
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    chk("load_ready", {7'd0, cfg_ready}, 8'd1);
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      cfg_valid = (i % 2 == 0);
      cfg_data  = cfg_valid ? ca[39-8*(i/2) -: 8] : 8'hA5;
      step();
      if (i % 2 == 0) acc++;
      chk($sformatf("tog_cfgd%0d", i), {7'd0, configured},
          {7'd0, acc == 5});
      chk($sformatf("tog_rdy%0d", i), {7'd0, cfg_ready},
          {7'd0, acc != 5});
    end
    cfg_valid = 1'b0;

    // bypass sum, same cycle, register untouched with lab_ce=0
    for (int p = 0; p < 4; p++) begin
      pv  = p[1:0];
      pia = pv;
      #1;
      chk($sformatf("byp_mc0_%0d", p), {7'd0, mc_out[0]},
          {7'd0, pv[0] | ~pv[1]});
      chk($sformatf("byp_mc1_%0d", p), {7'd0, mc_out[1]}, 8'd1);
      chk($sformatf("byp_exp_%0d", p), {6'd0, expander_out}, 8'd3);
    end

    // T toggle with pia0=1
    pia    = 2'b01;
    lab_ce = 1'b1;
    step();
    chk("t_tog1", {7'd0, mc_out[1]}, 8'd0);
    step();
    chk("t_tog2", {7'd0, mc_out[1]}, 8'd1);
    step();
    chk("t_tog3", {7'd0, mc_out[1]}, 8'd0);
    lab_ce = 1'b0;
    step();
    step();
    chk("t_hold", {7'd0, mc_out[1]}, 8'd0);

    // restart from RUN, then cfg_start collides with the 3rd beat
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    chk("rs_cfgd", {7'd0, configured}, 8'd0);
    chk("rs_mc", {6'd0, mc_out}, 8'd0);
    chk("rs_exp", {6'd0, expander_out}, 8'd0);
    for (int k = 0; k < 2; k++) begin
      cfg_valid = 1'b1;
      cfg_data  = cb[39-8*k -: 8];
      step();
      chk($sformatf("pre_mc%0d", k), {6'd0, mc_out}, 8'd0);
    end
    cfg_start = 1'b1;
    cfg_data  = cb[23:16];
    step();
    cfg_start = 1'b0;
    chk("col_ready", {7'd0, cfg_ready}, 8'd1);
    for (int k = 0; k < 5; k++) begin
      cfg_valid = 1'b1;
      cfg_data  = cb[39-8*k -: 8];
      step();
      chk($sformatf("col_cfgd%0d", k), {7'd0, configured},
          {7'd0, k == 4});
      if (k < 4) begin
        chk($sformatf("col_mc%0d", k), {6'd0, mc_out}, 8'd0);
        chk($sformatf("col_exp%0d", k), {6'd0, expander_out}, 8'd0);
      end
    end
    cfg_valid = 1'b0;

    // expander feeding a D register with inversion
    pia = 2'b11;
    #1;
    chk("ex_exp11", {6'd0, expander_out}, 8'b10);
    chk("ex_mc_pre", {6'd0, mc_out}, 8'd0);
    lab_ce = 1'b1;
    step();
    chk("ex_d11", {7'd0, mc_out[1]}, 8'd1);
    pia = 2'b01;
    #1;
    chk("ex_exp01", {6'd0, expander_out}, 8'b11);
    chk("ex_late", {7'd0, mc_out[1]}, 8'd1);
    step();
    chk("ex_d01", {7'd0, mc_out[1]}, 8'd0);
    pia = 2'b10;
    step();
    chk("ex_d10", {7'd0, mc_out[1]}, 8'd0);
    pia = 2'b11;
    step();
    chk("ex_d11b", {7'd0, mc_out[1]}, 8'd1);
    chk("ex_mc0", {7'd0, mc_out[0]}, 8'd0);
    lab_ce = 1'b0;

    // async reset mid-beat
    load(ca);
    pia = 2'b01;
    #1;
    chk("ra_mc", {6'd0, mc_out}, 8'd3);
    chk("ra_exp", {6'd0, expander_out}, 8'd3);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    cfg_valid = 1'b1;
    cfg_data  = ca[39:32];
    step();
    cfg_data = ca[31:24];
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_ready", {7'd0, cfg_ready}, 8'd0);
    chk("mid_cfgd", {7'd0, configured}, 8'd0);
    chk("mid_mc", {6'd0, mc_out}, 8'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    cfg_valid = 1'b0;
    chk("post_ready", {7'd0, cfg_ready}, 8'd0);
    chk("post_cfgd", {7'd0, configured}, 8'd0);
    load(ca);
    chk("rl_cfgd", {7'd0, configured}, 8'd1);
    chk("rl_mc", {6'd0, mc_out}, 8'd3);

    // async reset in RUN
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr_mc", {6'd0, mc_out}, 8'd0);
    chk("rr_exp", {6'd0, expander_out}, 8'd0);
    chk("rr_cfgd", {7'd0, configured}, 8'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("rr_stay", {7'd0, configured}, 8'd0);
    chk("rr_mc2", {6'd0, mc_out}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
